// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter that lends one 8-bit SPI master to N_REQ requesters, one byte per grant,
// with a done-edge detector, a timeout watchdog and per-device chip-select routing.
module spi_req_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] wdata,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   ack,
  output logic [7:0]         rdata,
  output logic               err,
  output logic               busy,
  output logic               m_start,
  output logic [7:0]         m_data_in,
  input  logic [7:0]         m_data_out,
  input  logic               m_done,
  input  logic               m_cs,
  output logic [N_REQ-1:0]   dev_cs_n
);

  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [N_REQ-1:0]  r_gnt;
  logic [IW-1:0]     r_sel;
  logic [IW-1:0]     r_last;
  logic [7:0]        r_dataIn;
  logic [7:0]        r_rdata;
  logic              r_err;
  logic [TW-1:0]     r_timer;
  logic              r_doneQ;
  logic [IW-1:0]     w_winner;
  logic              w_found;
  logic [N_REQ-1:0]  w_onehot;
  logic              w_doneRise;
  logic              w_timeout;

  // Search starts just past the last served requester so a held request queues behind the others.
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!w_found && req[(int'(r_last) + k) % N_REQ]) begin
        w_found  = 1'b1;
        w_winner = IW'((int'(r_last) + k) % N_REQ);
      end
    end
  end

  assign w_onehot   = {{(N_REQ-1){1'b0}}, 1'b1} << w_winner;
  assign w_doneRise = m_done & ~r_doneQ;
  assign w_timeout  = (r_timer == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    m_start = 1'b0;
    ack     = '0;
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        m_start = 1'b1;
        w_next  = S_WAIT;
      end
      S_WAIT: begin
        if (w_doneRise || w_timeout) begin
          w_next = S_ACK;
        end
      end
      S_ACK: begin
        ack    = r_gnt;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // done_q is primed in ISSUE so a done level left over from before the transfer is not an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_gnt    <= '0;
      r_sel    <= '0;
      r_last   <= IW'(N_REQ - 1);
      r_dataIn <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_timer  <= '0;
      r_doneQ  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_sel    <= w_winner;
            r_gnt    <= w_onehot;
            r_dataIn <= wdata[8*w_winner +: 8];
          end
        end
        S_ISSUE: begin
          r_timer <= '0;
          r_doneQ <= m_done;
        end
        S_WAIT: begin
          r_doneQ <= m_done;
          if (w_doneRise) begin
            r_rdata <= m_data_out;
            r_err   <= 1'b0;
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_ACK: begin
          r_last <= r_sel;
          r_gnt  <= '0;
        end
        default: ;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign rdata     = r_rdata;
  assign err       = r_err;
  assign busy      = (r_state != S_IDLE);
  assign m_data_in = r_dataIn;
  assign dev_cs_n  = {N_REQ{m_cs}} | ~r_gnt;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Scoreboard bench for spi_req_arbiter: the bench plays the SPI master, queues the expected
// grant/byte/result of every transfer and checks each ack pulse against the queue head.
module tb_spi_req_arbiter;

  localparam int N  = 4;
  localparam int TO = 64;

  logic         clock = 1'b0;
  logic         resetN;
  logic [N-1:0] req;
  logic [8*N-1:0] wdata;
  logic [N-1:0] gnt;
  logic [N-1:0] ack;
  logic [7:0]   rdata;
  logic         err;
  logic         busy;
  logic         mStart;
  logic [7:0]   mDataIn;
  logic [7:0]   mDataOut;
  logic         mDone;
  logic         mCs;
  logic [N-1:0] devCsN;

  typedef struct {
    logic [N-1:0] gnt;
    logic [7:0]   dataIn;
    logic [7:0]   rdata;
    logic         err;
    int           offset;
  } expT;

  expT expQ[$];

  int compared   = 0;
  int mismatched = 0;
  int cycle      = 0;
  int startCycle = 0;
  int startCount = 0;
  int ackCount   = 0;
  int masterMode = 0;
  int doneDelay  = 3;
  logic [7:0] respXor = 8'h00;

  spi_req_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk        (clock),
    .reset_n    (resetN),
    .req        (req),
    .wdata      (wdata),
    .gnt        (gnt),
    .ack        (ack),
    .rdata      (rdata),
    .err        (err),
    .busy       (busy),
    .m_start    (mStart),
    .m_data_in  (mDataIn),
    .m_data_out (mDataOut),
    .m_done     (mDone),
    .m_cs       (mCs),
    .dev_cs_n   (devCsN)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Sets the requester's byte, configures the slave behaviour and queues the expected outcome.
  task automatic applyStimulus(input int idx, input logic [7:0] data, input logic [7:0] xorVal,
                               input int mode, input logic [7:0] expRdata, input logic expErr,
                               input int offset);
    expT e;
    wdata[8*idx +: 8] = data;
    respXor    = xorVal;
    masterMode = mode;
    e.gnt    = N'(1) << idx;
    e.dataIn = data;
    e.rdata  = expRdata;
    e.err    = expErr;
    e.offset = offset;
    expQ.push_back(e);
    req[idx] = 1'b1;
  endtask

  task automatic waitStart(input int target, input int budget);
    for (int i = 0; i < budget && startCount < target; i++) begin
      @(negedge clock);
      #1;
    end
    if (startCount < target) checkOutput("startTimeout", startCount, target);
  endtask

  task automatic waitAcks(input int target, input int budget);
    for (int i = 0; i < budget && ackCount < target; i++) begin
      @(negedge clock);
      #1;
    end
    if (ackCount < target) checkOutput("ackTimeout", ackCount, target);
  endtask

  task automatic resetDut();
    resetN = 1'b0;
    repeat (2) @(negedge clock);
    expQ.delete();
    resetN = 1'b1;
  endtask

  // SPI master model: answers each start according to masterMode and checks the grant it served.
  initial begin : masterModel
    logic [N-1:0] expGnt;
    logic [N-1:0] expCs;
    mCs      = 1'b1;
    mDone    = 1'b0;
    mDataOut = 8'h00;
    forever begin
      @(negedge clock);
      if (mStart && resetN) begin
        startCycle = cycle;
        startCount++;
        if (expQ.size() == 0) begin
          checkOutput("unexpectedStart", 1, 0);
          expGnt = '0;
        end else begin
          expGnt = expQ[0].gnt;
          checkOutput("startGnt", gnt, expGnt);
          checkOutput("mDataIn", mDataIn, expQ[0].dataIn);
        end
        expCs = ~expGnt;
        mCs   = 1'b0;
        for (int j = 1; j <= 40; j++) begin
          @(negedge clock);
          if (!resetN) break;
          if (j == 1) begin
            checkOutput("startPulse", mStart, 0);
            checkOutput("devCsN", devCsN, expCs);
          end
          if (masterMode == 0) begin
            if (j == doneDelay) begin
              mDataOut = mDataIn ^ respXor;
              mDone    = 1'b1;
            end else if (j == doneDelay + 1) begin
              break;
            end
          end else if (masterMode == 1) begin
            if (j == 2) break;
          end else begin
            if (j == 2) begin
              mDone = 1'b0;
            end else if (j == 4) begin
              mDataOut = mDataIn ^ respXor;
              mDone    = 1'b1;
            end else if (j == 5) begin
              break;
            end
          end
        end
        mCs   = 1'b1;
        mDone = 1'b0;
      end
    end
  end

  // Every ack pulse retires the head of the scoreboard.
  initial begin : ackMonitor
    expT e;
    forever begin
      @(negedge clock);
      if (ack !== '0) begin
        ackCount++;
        if (expQ.size() == 0) begin
          checkOutput("unexpectedAck", ack, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("ack", ack, e.gnt);
          checkOutput("rdata", rdata, e.rdata);
          checkOutput("err", err, e.err);
          checkOutput("ackLatency", cycle - startCycle, e.offset);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int target;
    logic [7:0] rrData [4];
    resetN = 1'b0;
    req    = '0;
    wdata  = '0;
    repeat (2) @(negedge clock);
    #1;
    checkOutput("rstGnt", gnt, 0);
    checkOutput("rstAck", ack, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstStart", mStart, 0);
    checkOutput("rstDataIn", mDataIn, 0);
    checkOutput("rstRdata", rdata, 0);
    checkOutput("rstErr", err, 0);
    checkOutput("rstDevCs", devCsN, 4'b1111);
    @(negedge clock);
    resetN = 1'b1;
    @(negedge clock);

    $display("[TB] single transfer");
    applyStimulus(2, 8'hA5, 8'h99, 0, 8'h3C, 1'b0, 4);
    @(negedge clock);
    #1;
    checkOutput("gntLatency", gnt, 4'b0100);
    req = '0;
    waitAcks(1, 50);
    @(negedge clock);
    #1;
    checkOutput("ackOnePulse", ack, 0);
    checkOutput("rdataHeld", rdata, 8'h3C);

    $display("[TB] timeout");
    applyStimulus(3, 8'h77, 8'h00, 1, 8'h3C, 1'b1, TO + 1);
    waitStart(2, 20);
    req = '0;
    waitAcks(2, TO + 40);
    @(negedge clock);
    #1;
    checkOutput("busyAfterTimeout", busy, 0);
    checkOutput("errHeld", err, 1);
    checkOutput("rdataAfterTimeout", rdata, 8'h3C);

    $display("[TB] stale done");
    mDone = 1'b1;
    applyStimulus(0, 8'h5A, 8'hFF, 2, 8'hA5, 1'b0, 5);
    waitStart(3, 20);
    req = '0;
    waitAcks(3, 50);
    @(negedge clock);
    #1;
    checkOutput("errCleared", err, 0);

    $display("[TB] round robin");
    resetDut();
    @(negedge clock);
    rrData[0] = 8'h11;
    rrData[1] = 8'h22;
    rrData[2] = 8'h33;
    rrData[3] = 8'h44;
    target = ackCount + 5;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(i % 4, rrData[i % 4], 8'h0F, 0, rrData[i % 4] ^ 8'h0F, 1'b0, 4);
    end
    waitAcks(target, 200);
    req = '0;
    repeat (6) @(negedge clock);
    checkOutput("rrQueueDrained", expQ.size(), 0);

    $display("[TB] drop request and change data");
    target = startCount + 1;
    applyStimulus(1, 8'hC3, 8'h55, 0, 8'h96, 1'b0, 4);
    waitStart(target, 20);
    req[1] = 1'b0;
    wdata[15:8] = 8'hEE;
    waitAcks(ackCount + 1, 50);
    @(negedge clock);

    $display("[TB] reset during wait");
    doneDelay = 20;
    target = startCount + 1;
    applyStimulus(2, 8'h11, 8'h00, 0, 8'h11, 1'b0, 21);
    waitStart(target, 20);
    req = '0;
    repeat (3) @(negedge clock);
    #2;
    resetN = 1'b0;
    #1;
    checkOutput("midRstGnt", gnt, 0);
    checkOutput("midRstAck", ack, 0);
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstDevCs", devCsN, 4'b1111);
    expQ.delete();
    repeat (2) @(negedge clock);
    resetN = 1'b1;
    doneDelay = 3;
    repeat (3) @(negedge clock);
    #1;
    checkOutput("postRstRdata", rdata, 0);
    checkOutput("postRstBusy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
